// File: rtl/divider_controller.sv
// Multi-cycle 32-bit restoring divider controller (DIV / DIVU).
// Result packs {remainder, quotient}; ready follows the END state by one cycle.
module divider_controller (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        annul,
  input  logic        signed_div,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic [63:0] result,
  output logic        ready,
  output logic        stall_request
);

  typedef enum logic [1:0] {
    FREE,
    BY_ZERO,
    ON,
    END
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [64:0] work_q, work_d;
  logic [31:0] divisor_q, divisor_d;
  logic        a_neg_q, a_neg_d;
  logic        b_neg_q, b_neg_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [64:0] shifted;
  logic [32:0] trial;
  logic [64:0] step_work;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic        stall_raw;

  // One restoring step plus sign correction of the step's outcome.
  always_comb begin
    shifted   = {work_q[63:0], 1'b0};
    trial     = shifted[64:32] - {1'b0, divisor_q};
    step_work = shifted;
    if (!trial[32]) begin
      step_work = {trial, shifted[31:1], 1'b1};
    end
    quo_fix = (a_neg_q ^ b_neg_q) ? (~step_work[31:0] + 32'd1) : step_work[31:0];
    rem_fix = a_neg_q ? (~step_work[63:32] + 32'd1) : step_work[63:32];
  end

  // Next-state, datapath updates and stall request.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    a_neg_d   = a_neg_q;
    b_neg_d   = b_neg_q;
    result_d  = result_q;
    ready_d   = 1'b0;
    stall_raw = 1'b0;

    case (state_q)
      FREE: begin
        if (start && !annul) begin
          stall_raw = 1'b1;
          a_neg_d   = signed_div & operand_a[31];
          b_neg_d   = signed_div & operand_b[31];
          divisor_d = (signed_div && operand_b[31]) ? (~operand_b + 32'd1) : operand_b;
          work_d    = {33'd0, (signed_div && operand_a[31]) ? (~operand_a + 32'd1) : operand_a};
          cnt_d     = '0;
          state_d   = (operand_b == 32'd0) ? BY_ZERO : ON;
        end
      end
      BY_ZERO: begin
        stall_raw = 1'b1;
        result_d  = '0;
        state_d   = END;
      end
      ON: begin
        stall_raw = 1'b1;
        work_d    = step_work;
        cnt_d     = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          result_d = {rem_fix, quo_fix};
          state_d  = END;
        end
      end
      END: begin
        if (start) begin
          ready_d = 1'b1;
        end else begin
          result_d = '0;
          state_d  = FREE;
        end
      end
      default: state_d = FREE;
    endcase

    // A flush outside FREE discards any in-flight or finished divide.
    if (annul && state_q != FREE) begin
      state_d  = FREE;
      cnt_d    = '0;
      work_d   = '0;
      result_d = '0;
      ready_d  = 1'b0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= FREE;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      a_neg_q   <= 1'b0;
      b_neg_q   <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      a_neg_q   <= a_neg_d;
      b_neg_q   <= b_neg_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result        = result_q;
  assign ready         = ready_q;
  assign stall_request = stall_raw & ~reset;

endmodule

// File: tb/tb_divider_controller.sv
// Scoreboard bench for divider_controller: expected results queued at request time.
module tb_divider_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        annul;
  logic        signed_div;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [63:0] result;
  logic        ready;
  logic        stall_request;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [63:0] exp_q[$];

  always #5 clock = ~clock;

  divider_controller dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .annul        (annul),
    .signed_div   (signed_div),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .result       (result),
    .ready        (ready),
    .stall_request(stall_request)
  );

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [63:0] model(input logic sdiv, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return '0;
    if (sdiv) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic run_div(input string tag, input logic sdiv, input logic [31:0] a,
                         input logic [31:0] b, input int hold);
    int          cycles;
    int          stalls;
    int          exp_cycles;
    logic        got;
    logic [63:0] held;
    @(negedge clock);
    signed_div = sdiv;
    operand_a  = a;
    operand_b  = b;
    start      = 1'b1;
    annul      = 1'b0;
    exp_q.push_back(model(sdiv, a, b));
    exp_cycles = (b == 32'd0) ? 3 : 34;
    #1;
    check({tag, "/stall_req"}, 64'(stall_request), 64'd1);
    stalls = stall_request ? 1 : 0;
    cycles = 0;
    got    = 1'b0;
    while (!got && cycles < 60) begin
      @(negedge clock);
      cycles++;
      if (ready) got = 1'b1;
      else if (stall_request) stalls++;
      if (cycles == 1) begin
        operand_a  = $urandom;
        operand_b  = $urandom;
        signed_div = ~sdiv;
      end
    end
    check({tag, "/latency"}, 64'(cycles), 64'(exp_cycles));
    check({tag, "/stall_cycles"}, 64'(stalls), 64'(exp_cycles - 1));
    if (got) begin
      check({tag, "/result"}, result, exp_q.pop_front());
      check({tag, "/stall_end"}, 64'(stall_request), 64'd0);
    end else begin
      void'(exp_q.pop_front());
    end
    held = result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check({tag, "/hold_ready"}, 64'(ready), 64'd1);
      check({tag, "/hold_result"}, result, held);
    end
    start = 1'b0;
    @(negedge clock);
    check({tag, "/drop_ready"}, 64'(ready), 64'd0);
    check({tag, "/drop_result"}, result, 64'd0);
  endtask

  initial begin
    logic seen_ready;
    reset      = 1'b1;
    start      = 1'b1;
    annul      = 1'b0;
    signed_div = 1'b0;
    operand_a  = 32'd100;
    operand_b  = 32'd7;
    repeat (2) @(negedge clock);
    check("rst_result", result, 64'd0);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_stall", 64'(stall_request), 64'd0);
    reset = 1'b0;
    start = 1'b0;

    run_div("u100_7", 1'b0, 32'd100, 32'd7, 0);
    run_div("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    run_div("s7_-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 0);
    run_div("dbz5", 1'b0, 32'd5, 32'd0, 0);
    run_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_div("u_max", 1'b0, 32'hFFFF_FFFF, 32'd1, 0);
    run_div("s_hold", 1'b1, 32'hFFFF_FF9C, 32'd7, 5);
    run_div("s_dbz", 1'b1, 32'h8000_0000, 32'd0, 0);
    for (int i = 0; i < 4; i++) begin
      run_div($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), $urandom, $urandom_range(1, 32'hFFFF), 0);
    end

    // annul in the middle of a divide
    @(negedge clock);
    signed_div = 1'b0;
    operand_a  = 32'd100;
    operand_b  = 32'd7;
    start      = 1'b1;
    repeat (11) @(negedge clock);
    annul = 1'b1;
    @(negedge clock);
    check("abort_ready", 64'(ready), 64'd0);
    check("abort_result", result, 64'd0);
    check("abort_stall", 64'(stall_request), 64'd0);
    annul      = 1'b0;
    start      = 1'b0;
    seen_ready = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (ready) seen_ready = 1'b1;
    end
    check("abort_no_ready", 64'(seen_ready), 64'd0);
    run_div("after_abort9_3", 1'b0, 32'd9, 32'd3, 0);

    // reset in the middle of a divide
    @(negedge clock);
    signed_div = 1'b1;
    operand_a  = 32'hFFFF_FFF9;
    operand_b  = 32'd2;
    start      = 1'b1;
    repeat (21) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_result", result, 64'd0);
    check("midrst_ready", 64'(ready), 64'd0);
    check("midrst_stall", 64'(stall_request), 64'd0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clock);
    run_div("after_rst", 1'b1, 32'd1000, 32'hFFFF_FFFD, 0);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/divider_controller.md
DIVIDER_CONTROLLER -- requirements
Module: divider_controller

Interface
Parameters: none; datapath width is fixed at 32 bits.
REQ-001 The block SHALL have the ports below; clock and reset come first.
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  divide request from EX; held high until ready is seen.
- annul  input  1  abort (pipeline flush); overrides start.
- signed_div  input  1  1 = DIV (signed), 0 = DIVU (unsigned); sampled at acceptance.
- operand_a  input  32  dividend; sampled at acceptance.
- operand_b  input  32  divisor; sampled at acceptance.
- result  output  64  {remainder[63:32] -> hi, quotient[31:0] -> lo}; valid only while ready=1.
- ready  output  1  result valid; a registered output.
- stall_request  output  1  combinational; holds the pipeline while a divide is pending.

Function
REQ-002 The block SHALL be a four-state FSM: FREE, BY_ZERO, ON, END.
REQ-003 In FREE, start=1 with annul=0 SHALL accept the request.
- Capture signed_div and both operands.
- If operand_b==0, go to BY_ZERO; otherwise go to ON with the iteration counter = 0.
REQ-004 In FREE with start=0 or annul=1, the block SHALL stay in FREE.
REQ-005 In BY_ZERO, the block SHALL go to END on the next edge with the result forced to 64'b0.
REQ-006 When signed_div=1, the block SHALL divide magnitudes: operands with bit 31 set are replaced by their two's complement (~x+1) at acceptance.
REQ-007 In ON, the block SHALL run one restoring step per cycle on a 65-bit working register {partial_remainder, dividend_shift}.
- Step: trial = partial_remainder[32:0] - {1'b0, divisor}.
- If trial is non-negative, keep trial and shift in quotient bit 1; otherwise shift in 0.
REQ-008 The counter SHALL increment each ON cycle; after the 32nd step (counter==31) the next state SHALL be END.
REQ-009 On entering END, the block SHALL apply sign correction when signed_div=1.
- Quotient is negated if operand_a[31] differs from operand_b[31].
- Remainder is negated if operand_a[31]=1.
- Result is truncated toward zero.
REQ-010 -2^31 / -1 (signed) SHALL yield quotient 0x80000000 and remainder 0; no trap and no error flag.
REQ-011 In END, ready SHALL be 1 and result SHALL hold constant.
- Stay in END while start=1 and annul=0.
- start=0 SHALL return to FREE on the next edge: ready=0 and result=0.
REQ-012 annul=1 in BY_ZERO, ON or END SHALL return to FREE on the next edge: counter and result cleared, ready=0, no result produced.
REQ-013 stall_request SHALL be 1 when any of these holds:
- state==FREE with start=1 and annul=0;
- state==BY_ZERO;
- state==ON.
It SHALL be 0 otherwise, including throughout END.
REQ-014 Latency:
- Request accepted at edge k: ready=1 after edge k+33 (1 capture + 32 ON cycles).
- Divide-by-zero: ready=1 after edge k+2.
REQ-015 A new request SHALL only be accepted from FREE; start held high in END SHALL NOT restart a divide.
REQ-016 Operand changes after acceptance SHALL have no effect on the result.

Reset
REQ-017 When reset=1 at a rising edge, the block SHALL set state=FREE, counter=0, working register=0, result=64'b0 and ready=0, overriding all other inputs.
REQ-018 While reset=1, stall_request SHALL be 0.
REQ-019 Reset asserted mid-divide SHALL abort the divide; the first request after reset release SHALL complete normally.

Verification
REQ-020 Unsigned: 100 / 7, signed_div=0 -> ready 33 cycles after acceptance, result = {0x00000002, 0x0000000E}.
REQ-021 Signed: -7 / 2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1); 7 / -2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
REQ-022 Divide-by-zero: 5 / 0 -> ready after 2 cycles, result = 0; stall_request high for exactly 2 cycles.
REQ-023 Overflow plus unsigned corner:
- -2^31 / -1 signed -> {0x00000000, 0x80000000}.
- 0xFFFFFFFF / 1 unsigned -> {0x00000000, 0xFFFFFFFF}.
REQ-024 Abort: annul pulsed at ON cycle 10 -> FREE next cycle, ready never asserts; a following 9 / 3 request -> {0x00000000, 0x00000003}.
REQ-025 Reset and hold:
- Reset at ON cycle 20 -> all outputs 0 next cycle.
- start held 5 cycles in END -> result stable, no restart.
- start dropped -> FREE, ready=0.
